muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the MIPS32 EX stage, alongside the single-cycle ALU.
- Runs a 32-iteration radix-2 shift-add multiply or restoring divide.
- Owns the HI/LO architectural registers.
- Drives a busy/stall signal to the pipeline hazard logic.
- Services MTHI/MTLO writes.

---
 rtl/muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_sequencer.sv | 136 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide sequencer.
// master = EX-stage/hazard logic, slave = muldiv_sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// MIPS32 MULT/MULTU/DIV/DIVU sequencer owning HI/LO: radix-2 shift-add / restoring divide.
// Optional MULDIV_EARLY_ZERO_EN: zero operands (or divide by zero) skip RUN and finish at E1.
module muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   acc_hi, acc_lo, b;
  logic [XLEN-1:0]   hi_r, lo_r;
  logic              is_div, neg_q, neg_r, dbz, done_r;

  logic              sgn, rs_neg, rt_neg, skip;
  logic [XLEN-1:0]   rs_abs, rt_abs, init_hi, init_lo, init_b;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, fix_hi, fix_lo;

  assign sgn    = ~bus.op[0];
  assign rs_neg = sgn & bus.rs_val[XLEN-1];
  assign rt_neg = sgn & bus.rt_val[XLEN-1];
  assign rs_abs = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_abs = rt_neg ? -bus.rt_val : bus.rt_val;

`ifdef MULDIV_EARLY_ZERO_EN
  assign skip = bus.op[1] ? (bus.rt_val == '0)
                          : ((bus.rs_val == '0) || (bus.rt_val == '0));
`else
  assign skip = 1'b0;
`endif

  // Divide keeps the remainder in acc_hi and the dividend/quotient in acc_lo;
  // a skipped divide pre-loads acc_hi with |rs| so sign fix-up restores rs.
  always_comb begin
    init_b  = bus.op[1] ? rt_abs : rs_abs;
    init_hi = '0;
    init_lo = bus.op[1] ? rs_abs : rt_abs;
    if (skip) begin
      init_hi = bus.op[1] ? rs_abs : '0;
      init_lo = bus.op[1] ? '1 : '0;
    end
  end

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : '0);
    div_sh   = {acc_hi, acc_lo[XLEN-1]};
    div_diff = div_sh - {1'b0, b};
    if (is_div) begin
      nxt_hi = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
      nxt_lo = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = dbz ? '1 : (neg_q ? -acc_lo : acc_lo);
    r_fix    = neg_r ? -acc_hi : acc_hi;
    fix_hi   = is_div ? r_fix : prod_fix[2*XLEN-1:XLEN];
    fix_lo   = is_div ? q_fix : prod_fix[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      b      <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_r <= bus.wdata;
          if (bus.mtlo) lo_r <= bus.wdata;
          if (bus.start && !bus.flush) begin
            acc_hi <= init_hi;
            acc_lo <= init_lo;
            b      <= init_b;
            is_div <= bus.op[1];
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= rs_neg;
            dbz    <= bus.op[1] && (bus.rt_val == '0);
            cnt    <= '0;
            state  <= skip ? FIX : RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) state <= FIX;
          end
        end
        FIX: begin
          if (!bus.flush) begin
            hi_r   <= fix_hi;
            lo_r   <= fix_lo;
            done_r <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: table of ops plus hand sequences
// for flush, start-while-busy, MTHI/MTLO and asynchronous reset.
module tb_muldiv_sequencer;

`ifdef MULDIV_EARLY_ZERO_EN
  localparam bit EZ = 1'b1;
`else
  localparam bit EZ = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    if (EZ && (op[1] ? (rt == 32'd0) : (rs == 32'd0 || rt == 32'd0))) return 1;
    return 33;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      step();
      n++;
    end
  endtask

  initial begin
    int lat, bcnt, nd;
    logic [31:0] mhi, mlo;
    total = 0;
    bad   = 0;

    vecs[0]  = '{2'd1, 32'd3,        32'd5,        32'd0,        32'd15};
    vecs[1]  = '{2'd0, 32'hFFFFFFFE, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[2]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6]  = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7]  = '{2'd0, 32'd0,        32'd9,        32'd0,        32'd0};
    vecs[8]  = '{2'd0, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'd0,        32'd12};
    vecs[9]  = '{2'd3, 32'd50,       32'd5,        32'd0,        32'd10};
    vecs[10] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[11] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[12] = '{2'd3, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.flush  = 1'b0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.wdata  = '0;
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(lat, bcnt);
      chk($sformatf("v%0d_lat", i), lat, exp_lat(vecs[i].op, vecs[i].rs, vecs[i].rt));
      chk($sformatf("v%0d_busycyc", i), bcnt, exp_lat(vecs[i].op, vecs[i].rs, vecs[i].rt));
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].elo);
      chk($sformatf("v%0d_busy_at_done", i), bus.busy, 0);
      step();
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
    end
    mhi = vecs[12].ehi;
    mlo = vecs[12].elo;

    // MTLO / MTHI while idle
    @(negedge clk);
    bus.mtlo = 1'b1; bus.wdata = 32'h1234;
    step();
    bus.mtlo = 1'b0;
    chk("mtlo_idle_lo", bus.lo, 32'h1234);
    chk("mtlo_idle_hi", bus.hi, mhi);
    mlo = 32'h1234;
    @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'hABCD;
    step();
    bus.mthi = 1'b0;
    chk("mthi_idle_hi", bus.hi, 32'hABCD);
    mhi = 32'hABCD;

    // flush mid-RUN
    launch(2'd3, 32'd50, 32'd5);
    repeat (9) step();
    chk("flush_pre_busy", bus.busy, 1);
    @(negedge clk);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_hi", bus.hi, mhi);
    chk("flush_lo", bus.lo, mlo);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) nd++;
      step();
    end
    chk("flush_no_done", nd, 0);

    // MTLO while busy is ignored, result lands afterwards
    launch(2'd3, 32'd50, 32'd5);
    repeat (5) step();
    @(negedge clk);
    bus.mtlo = 1'b1; bus.wdata = 32'hDEAD;
    step();
    bus.mtlo = 1'b0;
    chk("mtlo_busy_lo", bus.lo, mlo);
    wait_done(lat, bcnt);
    chk("mtlo_busy_to", lat < 100, 1);
    chk("mtlo_busy_res_lo", bus.lo, 10);
    chk("mtlo_busy_res_hi", bus.hi, 0);
    step();

    // start pulsed while busy is dropped
    launch(2'd1, 32'd6, 32'd7);
    repeat (3) step();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.rs_val = 32'd9; bus.rt_val = 32'd0;
    step();
    bus.start = 1'b0;
    nd = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done === 1'b1) nd++;
      step();
    end
    chk("busy_start_dones", nd, 1);
    chk("busy_start_lo", bus.lo, 42);
    chk("busy_start_hi", bus.hi, 0);

    // MTLO together with start: write lands, result overwrites
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
    bus.mtlo = 1'b1; bus.wdata = 32'h55;
    step();
    bus.start = 1'b0; bus.mtlo = 1'b0;
    chk("mtlo_start_lo", bus.lo, 32'h55);
    chk("mtlo_start_busy", bus.busy, 1);
    wait_done(lat, bcnt);
    chk("mtlo_start_res_lo", bus.lo, 6);
    step();

    // flush with start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd1; bus.rs_val = 32'd4; bus.rt_val = 32'd4;
    step();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_busy", bus.busy, 0);
    step();
    chk("flush_start_done", bus.done, 0);

    // flush on the FIX edge wins
    @(negedge clk);
    bus.mtlo = 1'b1; bus.wdata = 32'h777;
    step();
    bus.mtlo = 1'b0;
    launch(2'd1, 32'd3, 32'd5);
    repeat (32) step();
    chk("fixflush_pre_busy", bus.busy, 1);
    @(negedge clk);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fixflush_done", bus.done, 0);
    chk("fixflush_busy", bus.busy, 0);
    chk("fixflush_lo", bus.lo, 32'h777);

    // asynchronous reset mid-RUN
    @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'h99;
    step();
    bus.mthi = 1'b0;
    launch(2'd0, 32'hFFFFFFFE, 32'd7);
    repeat (10) step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    launch(2'd1, 32'd3, 32'd5);
    wait_done(lat, bcnt);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_hi", bus.hi, 0);
    chk("post_rst_lo", bus.lo, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
